// File: rtl/score_bcd_counter.sv
// Game score accumulator: turns hit/miss pulses into a 4-digit BCD score with a
// combo multiplier. Earned points are queued in a pending count and drained one per cycle.
module score_bcd_counter #(
    parameter int COMBO_STEP = 8,
    parameter int MAX_MULT   = 4,
    parameter int PEND_W     = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hit,
    input  logic       miss,
    input  logic       clear,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic [7:0] combo,
    output logic [2:0] multiplier,
    output logic       busy,
    output logic       saturated
);

    localparam int SUM_W = PEND_W + 3;
    localparam logic [SUM_W-1:0] PEND_MAX = SUM_W'((1 << PEND_W) - 1);

    logic [3:0]        digs [4];
    logic [3:0]        inc_digs [4];
    logic [PEND_W-1:0] pending;
    logic [7:0]        combo_steps;
    logic              drain;
    logic              award;
    logic              lands_on_top;
    logic [SUM_W-1:0]  pend_sum;
    logic [PEND_W-1:0] pend_next;
    logic              carry;

    always_comb begin
        combo_steps = combo / 8'(COMBO_STEP);
        if (combo_steps >= 8'(MAX_MULT - 1))
            multiplier = 3'(MAX_MULT);
        else
            multiplier = 3'(combo_steps) + 3'd1;
    end

    // Ripple the +1 through all four digits in one cycle, wrapping 9 -> 0.
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            inc_digs[i] = digs[i];
            if (carry) begin
                if (digs[i] == 4'd9) begin
                    inc_digs[i] = 4'd0;
                end else begin
                    inc_digs[i] = digs[i] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

    always_comb begin
        drain        = (pending != '0) && !saturated;
        award        = hit && !miss && !saturated;
        lands_on_top = (digs[3] == 4'd9) && (digs[2] == 4'd9) &&
                       (digs[1] == 4'd9) && (digs[0] == 4'd8);
        pend_sum     = SUM_W'(pending) - SUM_W'(drain) + (award ? SUM_W'(multiplier) : '0);
        if (pend_sum > PEND_MAX)
            pend_next = PEND_MAX[PEND_W-1:0];
        else
            pend_next = pend_sum[PEND_W-1:0];
    end

    // Reaching 9999 freezes the score and throws away anything still queued.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int i = 0; i < 4; i++) digs[i] <= 4'd0;
            combo     <= 8'd0;
            pending   <= '0;
            saturated <= 1'b0;
        end else begin
            if (miss)
                combo <= 8'd0;
            else if (hit && combo != 8'd255)
                combo <= combo + 8'd1;

            if (drain) begin
                for (int i = 0; i < 4; i++) digs[i] <= inc_digs[i];
            end

            if (drain && lands_on_top) begin
                saturated <= 1'b1;
                pending   <= '0;
            end else begin
                pending <= pend_next;
            end
        end
    end

    assign dig0 = digs[0];
    assign dig1 = digs[1];
    assign dig2 = digs[2];
    assign dig3 = digs[3];
    assign busy = (pending != '0);

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter: an arithmetic score model queues the expected
// state per cycle and a monitor compares it against the DUT one step after each edge.
module tb_score_bcd_counter;

    logic       clk = 1'b0;
    logic       reset, hit, miss, clear;
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [7:0] combo;
    logic [2:0] multiplier;
    logic       busy, saturated;

    typedef struct {
        int score;
        int combo;
        int mult;
        int busy;
        int sat;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    int m_score = 0;
    int m_pend  = 0;
    int m_combo = 0;
    int m_sat   = 0;

    score_bcd_counter dut (
        .clk        (clk),
        .reset      (reset),
        .hit        (hit),
        .miss       (miss),
        .clear      (clear),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .dig3       (dig3),
        .combo      (combo),
        .multiplier (multiplier),
        .busy       (busy),
        .saturated  (saturated)
    );

    always #5 clk = ~clk;

    function automatic int model_mult(input int c);
        int m;
        m = 1 + c / 8;
        return (m > 4) ? 4 : m;
    endfunction

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("dig0", int'(dig0), e.score % 10);
        checkField("dig1", int'(dig1), (e.score / 10) % 10);
        checkField("dig2", int'(dig2), (e.score / 100) % 10);
        checkField("dig3", int'(dig3), (e.score / 1000) % 10);
        checkField("combo", int'(combo), e.combo);
        checkField("multiplier", int'(multiplier), e.mult);
        checkField("busy", int'(busy), e.busy);
        checkField("saturated", int'(saturated), e.sat);
    endtask

    // Drive one cycle of inputs and queue what the design must show after the next edge.
    task automatic applyStimulus(input logic r, input logic h, input logic m, input logic c);
        exp_t e;
        int   drain;
        int   add;
        @(negedge clk);
        reset = r; hit = h; miss = m; clear = c;
        if (r || c) begin
            m_score = 0; m_pend = 0; m_combo = 0; m_sat = 0;
        end else begin
            drain = (m_pend > 0 && m_sat == 0) ? 1 : 0;
            add   = (h && !m && m_sat == 0) ? model_mult(m_combo) : 0;
            if (m)      m_combo = 0;
            else if (h) m_combo = (m_combo < 255) ? m_combo + 1 : 255;
            m_score = m_score + drain;
            m_pend  = m_pend - drain + add;
            if (m_pend > 31) m_pend = 31;
            if (drain == 1 && m_score == 9999) begin
                m_sat  = 1;
                m_pend = 0;
            end
        end
        e.score = m_score;
        e.combo = m_combo;
        e.mult  = model_mult(m_combo);
        e.busy  = (m_pend != 0) ? 1 : 0;
        e.sat   = m_sat;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : stimulus
        int unsigned r;
        int          n;
        reset = 1'b1; hit = 1'b0; miss = 1'b0; clear = 1'b0;

        repeat (2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (9) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(15);

        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(25);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(8);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);
        repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(3);

        for (int i = 0; i < 1500; i++) begin
            r = $urandom;
            applyStimulus((r % 500) == 0, (r[8:7] != 2'b00), (r[15:10] == 6'd0), ((r >> 16) % 400) == 0);
        end

        // Long run without restarts so the score climbs through every carry up to 9999.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (m_sat == 0 && n < 40000) begin
            r = $urandom;
            applyStimulus(1'b0, (r % 3) == 0, (r[15:10] == 6'd0) && (r[5:4] == 2'b00), 1'b0);
            n++;
        end
        if (m_sat == 0) begin
            errors++;
            $display("[TB] FAIL reach_9999: model score %0d, expected 9999 within budget", m_score);
        end
        repeat (20) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        idle(3);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        idle(4);

        n = 0;
        while (exp_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
